fir_stream_feeder: RTL and testbench

Initiator-side driver for the FIR filter's single-sample handshake. It accepts input samples on a valid/ready stream and buffers them in a FIFO. It issues each sample to the FIR as a one-cycle `input_valid` pulse, waits for the FIR's `output_valid` rising edge, and then presents the captured result on a valid/ready output stream. It sits between a sample source (ADC/memory reader) and the FIR, replacing the bench-style stimulus loop in synthesizable form.

---
 rtl/fir_stream_feeder.sv | 93 +++++++++
 tb/tb_fir_stream_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_feeder.sv
// fir_stream_feeder: FIFO-buffered single-sample handshake driver for the FIR; FEEDER_TIMEOUT_EN builds the WAIT abort path.
module fir_stream_feeder #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 38,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  output logic                 fir_input_valid,
  output logic [IN_WIDTH-1:0]  fir_input_data,
  input  logic                 fir_output_valid,
  input  logic [OUT_WIDTH-1:0] fir_output_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 busy,
  output logic [15:0]          sample_count,
  output logic                 timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_nxt;
  logic [IN_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic push, pop, empty, fov_q, edge_hit, abort;
  assign empty = level == '0;
  assign s_ready = level != (AW+1)'(FIFO_DEPTH);
  assign push = s_valid && s_ready;
  // Only a fresh 0->1 transition counts, so a level left high from before is ignored.
  assign edge_hit = fir_output_valid && !fov_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE  ? (empty ? IDLE : ISSUE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? (edge_hit ? HOLD : abort ? IDLE : WAIT) :
                m_ready        ? (empty ? IDLE : ISSUE) : HOLD;
  end
  always_comb begin
    fir_input_valid = state == ISSUE;
    m_valid = state == HOLD;
    busy = state != IDLE || !empty;
    pop = !empty && (state == IDLE || (state == HOLD && m_ready));
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      fir_input_data <= '0;
      m_data <= '0;
      fov_q <= 1'b0;
      sample_count <= '0;
    end else begin
      fov_q <= fir_output_valid;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        fir_input_data <= mem[rd_ptr];
      end
      if (state == WAIT && edge_hit) m_data <= fir_output_data;
      if (state == HOLD && m_ready) sample_count <= sample_count + 16'd1;
    end
  end
`ifdef FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  assign abort = state == WAIT && !edge_hit && wait_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= state == ISSUE ? '0 : state == WAIT ? wait_cnt + 1'b1 : wait_cnt;
      if (abort) timeout_err <= 1'b1;
    end
  end
`else
  assign abort = TIMEOUT < 0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_fir_stream_feeder.sv
// tb_fir_stream_feeder: directed/random bench with a latency-based FIR model and an in-order result queue.
module tb_fir_stream_feeder;
  localparam int IW = 16;
  localparam int OW = 38;
  localparam int LAT = 65;
  logic clk = 0, rst = 1, s_valid = 0, s_ready, fir_input_valid, fir_output_valid = 0;
  logic m_valid, m_ready = 1, busy, timeout_err;
  logic [IW-1:0] s_data = 0, fir_input_data;
  logic [OW-1:0] fir_output_data = 0, m_data;
  logic [15:0] sample_count;
  fir_stream_feeder dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_input_valid(fir_input_valid), .fir_input_data(fir_input_data),
    .fir_output_valid(fir_output_valid), .fir_output_data(fir_output_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .sample_count(sample_count), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int n_cmp = 0, n_err = 0;
  logic [OW-1:0] exp_q[$];
  int hs_cnt = 0, issue_cnt = 0, mv_cnt = 0, edge_cyc = -100, due = -1, last_issue = -1;
  logic [OW-1:0] due_d;
  bit fir_en = 1;
  logic mv_prev = 0;

  function automatic logic [OW-1:0] fir_ref(input logic [IW-1:0] x);
    return OW'(x) * 38'd1000003 + 38'd17;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] d);
    int k = 0;
    s_valid = 1;
    s_data = d;
    while (!s_ready && k < 500) begin
      step(1);
      k++;
    end
    chk("push_accept", s_ready, 1);
    exp_q.push_back(fir_ref(d));
    step(1);
    s_valid = 0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k = 0;
    while (hs_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_handshake", hs_cnt >= target, 1);
  endtask

  // Monitor first, then the FIR model, so both see the same mid-cycle snapshot.
  always @(negedge clk) begin
    if (rst) begin
      fir_output_valid = 0;
      due = -1;
      mv_prev = 0;
      hs_cnt = 0;
    end else begin
      if (m_valid && !mv_prev) chk("m_valid_latency", cyc, edge_cyc + 1);
      mv_prev = m_valid;
      if (m_valid) mv_cnt++;
      if (m_valid && m_ready) begin
        hs_cnt++;
        chk("result_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("m_data", m_data, exp_q.pop_front());
      end
      if (fir_input_valid) begin
        issue_cnt++;
        last_issue = cyc;
        if (fir_en) begin
          due = cyc + LAT;
          due_d = fir_ref(fir_input_data);
        end
      end
      fir_output_valid = cyc == due;
      if (cyc == due) begin
        fir_output_data = due_d;
        edge_cyc = cyc;
      end
    end
  end

  initial begin
    logic [IW-1:0] x0;
    logic [15:0] sc_exp;
    int base, ic, mv0, k;
    step(3);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fiv", fir_input_valid, 0);
    chk("rst_fid", fir_input_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 0;
    step(2);
    push(16'h0001);
    chk("t1_pop_cycle_fiv", fir_input_valid, 0);
    step(1);
    chk("t1_issue_fiv", fir_input_valid, 1);
    chk("t1_issue_data", fir_input_data, 16'h0001);
    step(1);
    chk("t1_pulse_end", fir_input_valid, 0);
    wait_hs(1, 200);
    step(1);
    chk("t1_count", sample_count, 1);
    step(2);
    base = hs_cnt;
    for (int i = 0; i < 9; i++) push(IW'($urandom));
    chk("t2_full", s_ready, 0);
    chk("t2_busy", busy, 1);
    push(IW'($urandom));
    wait_hs(base + 10, 2000);
    step(3);
    chk("t2_idle", busy, 0);
    chk("t2_count", sample_count, 16'(hs_cnt));
    chk("t2_drained", exp_q.size(), 0);
    m_ready = 0;
    base = hs_cnt;
    push(IW'($urandom));
    push(IW'($urandom));
    k = 0;
    while (!m_valid && k < 300) begin
      step(1);
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_valid", m_valid, 1);
      chk("t3_hold_data", m_data, exp_q[0]);
      chk("t3_no_issue", fir_input_valid, 0);
      step(1);
    end
    m_ready = 1;
    step(1);
    chk("t3_reissue", fir_input_valid, 1);
    wait_hs(base + 2, 300);
    step(3);
    fir_en = 0;
    ic = issue_cnt;
    mv0 = mv_cnt;
    x0 = IW'($urandom);
    push(x0);
    for (int i = 0; i < 3; i++) push(IW'($urandom));
`ifdef FEEDER_TIMEOUT_EN
    k = 0;
    while (cyc < last_issue + 127 && k < 300) begin
      step(1);
      k++;
    end
    chk("t4_before_timeout", timeout_err, 0);
    step(1);
    chk("t4_timeout", timeout_err, 1);
    chk("t4_no_m_valid", m_valid, 0);
    step(1);
    chk("t4_next_issue", fir_input_valid, 1);
    chk("t4_mv_count", mv_cnt, mv0);
    void'(exp_q.pop_front());
`else
    step(150);
    chk("t4_single_issue", issue_cnt, ic + 1);
    chk("t4_no_m_valid", mv_cnt, mv0);
    chk("t4_busy", busy, 1);
    chk("t4_timeout_off", timeout_err, 0);
    chk("t4_data_stable", fir_input_data, x0);
`endif
    step(5);
    #2;
    rst = 1;
    #1;
    chk("t5_s_ready", s_ready, 1);
    chk("t5_fiv", fir_input_valid, 0);
    chk("t5_fid", fir_input_data, 0);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_count", sample_count, 0);
    chk("t5_timeout", timeout_err, 0);
    step(2);
    exp_q.delete();
    fir_en = 1;
    rst = 0;
    mv0 = mv_cnt;
    step(200);
    chk("t5_no_m_valid", mv_cnt, mv0);
    chk("t5_idle", busy, 0);
    force dut.sample_count = 16'hFFFF;
    step(1);
    release dut.sample_count;
    step(1);
    sc_exp = 16'hFFFF;
    chk("t6_preset", sample_count, sc_exp);
    push(IW'($urandom));
    wait_hs(hs_cnt + 1, 300);
    step(1);
    sc_exp++;
    chk("t6_wrap", sample_count, sc_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
